// File: rtl/ivs_bitmap_idx_drain.sv
// Drains a W-bit request bitmap as binary indices, lowest set bit first; out_vld one cycle after accept.
// Outputs hold while out_rdy is low; a new bitmap is taken in IDLE or on the last-beat handshake.
module ivs_bitmap_idx_drain #(
  parameter int W  = 32,
  parameter int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [W-1:0]  in_map,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [IW-1:0] out_idx,
  output logic [W-1:0]  out_oh,
  output logic [IW-1:0] out_seq,
  output logic          out_last,
  output logic          busy,
  output logic [15:0]   zero_cnt
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  map_q, map_d;
  logic [IW-1:0] seq_q, seq_d;
  logic [15:0]   zcnt_q, zcnt_d;

  logic [W-1:0]  lsb_oh;
  logic [W-1:0]  rest;
  logic [IW-1:0] lsb_idx;
  logic          last_w;
  logic          fire_out;
  logic          fire_in;

  // Isolate the lowest remaining set bit; the remainder decides out_last.
  assign lsb_oh = map_q & (~map_q + W'(1));
  assign rest   = map_q & ~lsb_oh;
  assign last_w = (map_q != '0) && (rest == '0);

  always_comb begin
    lsb_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb_oh[i]) lsb_idx = IW'(i);
    end
  end

  // Outputs are gated by rst so the reset cycle itself shows no beat and no ready.
  assign busy     = (state_q == DRAIN) && !rst;
  assign out_vld  = busy;
  assign out_idx  = out_vld ? lsb_idx : '0;
  assign out_oh   = out_vld ? lsb_oh  : '0;
  assign out_seq  = out_vld ? seq_q   : '0;
  assign out_last = out_vld & last_w;
  assign zero_cnt = zcnt_q;

  assign fire_out = out_vld & out_rdy;
  assign in_rdy   = !rst && ((state_q == IDLE) || (fire_out && last_w));
  assign fire_in  = in_vld & in_rdy;

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    seq_d   = seq_q;
    zcnt_d  = zcnt_q;
    if (fire_out) begin
      map_d = rest;
      seq_d = seq_q + IW'(1);
      if (last_w) state_d = IDLE;
    end
    // A bitmap taken on the last-beat cycle overrides the drain update above.
    if (fire_in) begin
      if (in_map != '0) begin
        map_d   = in_map;
        seq_d   = '0;
        state_d = DRAIN;
      end else begin
        state_d = IDLE;
        if (zcnt_q != 16'hFFFF) zcnt_d = zcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      map_q   <= '0;
      seq_q   <= '0;
      zcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      seq_q   <= seq_d;
      zcnt_q  <= zcnt_d;
    end
  end

endmodule

// File: tb/tb_ivs_bitmap_idx_drain.sv
// Scoreboard bench for ivs_bitmap_idx_drain: directed cases plus randomised maps and ready.
module tb_ivs_bitmap_idx_drain;

  localparam int W  = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [W-1:0]  in_map;
  logic          out_vld;
  logic          out_rdy;
  logic [IW-1:0] out_idx;
  logic [W-1:0]  out_oh;
  logic [IW-1:0] out_seq;
  logic          out_last;
  logic          busy;
  logic [15:0]   zero_cnt;

  ivs_bitmap_idx_drain #(.W(W), .IW(IW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_map(in_map),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_idx(out_idx), .out_oh(out_oh),
    .out_seq(out_seq), .out_last(out_last), .busy(busy), .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [IW-1:0] seq;
    logic          last;
  } beat_t;

  beat_t        sb[$];
  logic [W-1:0] mapq[$];
  int           checks   = 0;
  int           errors   = 0;
  int           exp_zero = 0;
  bit           rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expect(input logic [W-1:0] m);
    int            hi;
    logic [IW-1:0] s;
    beat_t         b;
    hi = 0;
    s  = '0;
    if (m == '0) begin
      exp_zero++;
    end else begin
      mapq.push_back(m);
      for (int i = 0; i < W; i++) if (m[i]) hi = i;
      for (int i = 0; i < W; i++) begin
        if (m[i]) begin
          b.idx  = IW'(i);
          b.seq  = s;
          b.last = (i == hi);
          sb.push_back(b);
          s++;
        end
      end
    end
  endtask

  // Present a bitmap until accepted; returns 1 time unit after the accepting edge.
  task automatic offer(input logic [W-1:0] m);
    int t;
    t      = 0;
    in_vld = 1'b1;
    in_map = m;
    @(negedge clk);
    while (!in_rdy && t < 1000) begin
      t++;
      @(negedge clk);
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: map 0x%0h never accepted", m);
    end else begin
      push_expect(m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_wait();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_vld) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  logic [W-1:0]  acc;
  logic          prev_stall;
  logic [43:0]   prev_snap;
  logic [IW-1:0] prev_idx;
  beat_t         e;

  initial begin
    acc = '0; prev_stall = 1'b0; prev_snap = '0; prev_idx = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      acc        = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {out_vld, out_idx, out_seq, out_last, out_oh}, prev_snap);
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: idx %0d with empty scoreboard", out_idx);
        end else begin
          e = sb.pop_front();
          chk("beat", {out_idx, out_oh, out_seq, out_last}, {e.idx, W'(1) << e.idx, e.seq, e.last});
          if (out_seq != '0) chk("idx_increasing", out_idx > prev_idx, 1);
          prev_idx = out_idx;
          acc      = acc | out_oh;
          if (out_last) begin
            if (mapq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_last: out_last with no map pending");
            end else begin
              chk("map_cover", acc, mapq.pop_front());
            end
            acc = '0;
          end
        end
      end
      prev_stall = out_vld && !out_rdy;
      prev_snap  = {out_vld, out_idx, out_seq, out_last, out_oh};
    end
  end

  initial begin
    logic [W-1:0] m;
    rst = 1'b1; in_vld = 1'b0; in_map = '0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_rdy", in_rdy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_rdy", in_rdy, 1);
    chk("idle_zero_cnt", zero_cnt, 0);
    chk("idle_outs", {out_idx, out_oh, out_seq, out_last}, 0);
    @(posedge clk);
    #1;

    // 1: three sparse bits, latency 1
    offer(32'h8000_0011);
    in_vld = 1'b0;
    @(negedge clk);
    chk("t1_latency", out_vld, 1);
    drain_wait();

    // 2: stall on beat 0 for three cycles
    out_rdy = 1'b0;
    offer(32'h0000_0006);
    in_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_stall", {out_vld, out_idx, out_last, in_rdy}, {1'b1, 5'd1, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1 out_rdy = 1'b1;
    @(negedge clk);
    chk("t2_in_rdy_beat0", in_rdy, 0);
    drain_wait();

    // 3: zero bitmaps
    offer('0);
    offer('0);
    in_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_no_beat", {out_vld, in_rdy}, 2'b01);
    end
    chk("t3_zero_cnt", zero_cnt, 2);
    @(posedge clk);
    #1;

    // 4: back-to-back single-bit maps without a bubble
    offer(32'h1);
    offer(32'h8);
    in_vld = 1'b0;
    @(negedge clk);
    chk("t4_no_bubble", {out_vld, out_idx, out_seq, out_last}, {1'b1, 5'd3, 5'd0, 1'b1});
    drain_wait();

    // 5: full map, then reset during beat 5 of another full map
    offer(32'hFFFF_FFFF);
    in_vld = 1'b0;
    drain_wait();
    offer(32'hFFFF_FFFF);
    in_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    mapq.delete();
    exp_zero = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_vld", out_vld, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_zero_cnt", zero_cnt, 0);
    chk("t5_rst_in_rdy", in_rdy, 1);
    @(posedge clk);
    #1;

    // 6: randomised maps under random downstream ready
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case (n % 4)
        0:       m = $urandom;
        1:       m = $urandom & $urandom & $urandom;
        2:       m = (n % 16 == 2) ? '0 : (W'(1) << $urandom_range(0, W - 1));
        default: m = $urandom | 32'h8000_0001;
      endcase
      offer(m);
      if ($urandom_range(0, 3) == 0) begin
        in_vld = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_vld   = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_rdy = 1'b1;
    drain_wait();
    chk("t6_zero_cnt", zero_cnt, exp_zero);
    chk("t6_sb_empty", sb.size(), 0);
    chk("t6_maps_closed", mapq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
